// File: rtl/serv_dbus_resp.sv
// Data-bus responder for the SERV load/store port: a local word array with
// byte-lane writes, sticky out-of-range flag and a fixed ack wait.
module serv_dbus_resp #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_oor
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:2] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] rdt_q;
  logic        oor_q;
  logic [31:0] mem [DEPTH];

  logic [31:2] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        req_we;
  logic [AW-1:0] req_idx;
  logic        req_oor;
  logic        enter_ack;
  logic        unused_adr_lsb;

  assign unused_adr_lsb = ^i_wb_adr[1:0];

  // With WAIT=0 the accept edge is also the commit edge, so the live inputs
  // stand in for the not-yet-captured request.
  assign req_adr   = (state == IDLE) ? i_wb_adr[31:2] : adr_q;
  assign req_dat   = (state == IDLE) ? i_wb_dat       : dat_q;
  assign req_sel   = (state == IDLE) ? i_wb_sel       : sel_q;
  assign req_we    = (state == IDLE) ? i_wb_we        : we_q;
  assign req_idx   = req_adr[AW+1:2];
  assign req_oor   = |req_adr[31:AW+2];
  assign enter_ack = (state_next == ACK);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = 4'd0;
        if (i_wb_cyc) state_next = (WAIT == 0) ? ACK : BUSY;
      end
      BUSY: begin
        if (!i_wb_cyc)              state_next = IDLE;
        else if (cnt == WAIT_LAST)  state_next = ACK;
        else                        cnt_next   = cnt + 4'd1;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdt_q <= 32'h0;
      oor_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rdt_q <= (enter_ack && !req_oor) ? mem[req_idx] : 32'h0;
      oor_q <= oor_q | (enter_ack & req_oor);
    end
  end

  // Request capture and the array itself carry no reset.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_wb_cyc) begin
      adr_q <= i_wb_adr[31:2];
      dat_q <= i_wb_dat;
      sel_q <= i_wb_sel;
      we_q  <= i_wb_we;
    end
    if (enter_ack && req_we && !req_oor) begin
      for (int n = 0; n < 4; n++) begin
        if (req_sel[n]) mem[req_idx][8*n +: 8] <= req_dat[8*n +: 8];
      end
    end
  end

  assign o_wb_ack = (state == ACK);
  assign o_wb_rdt = rdt_q;
  assign o_oor    = oor_q;

endmodule

// File: tb/tb_serv_dbus_resp.sv
// Directed bench for serv_dbus_resp: one instance with WAIT=0 and one with WAIT=3.
module tb_serv_dbus_resp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc0, we0, ack0, oor0;
  logic [31:0] adr0, dat0, rdt0;
  logic [3:0]  sel0;
  logic        cyc3, we3, ack3, oor3;
  logic [31:0] adr3, dat3, rdt3;
  logic [3:0]  sel3;

  int checks = 0;
  int errors = 0;

  serv_dbus_resp #(.DEPTH(256), .WAIT(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc0), .i_wb_adr(adr0), .i_wb_dat(dat0),
    .i_wb_sel(sel0), .i_wb_we(we0), .o_wb_rdt(rdt0), .o_wb_ack(ack0), .o_oor(oor0)
  );

  serv_dbus_resp #(.DEPTH(256), .WAIT(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc3), .i_wb_adr(adr3), .i_wb_dat(dat3),
    .i_wb_sel(sel3), .i_wb_we(we3), .o_wb_rdt(rdt3), .o_wb_ack(ack3), .o_oor(oor3)
  );

  // Runs one request on the chosen instance; lat is the cycle count from accept to ack, 0 if none.
  task automatic txn(input bit slow, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdt, output int lat);
    @(negedge clk);
    if (slow) begin cyc3 = 1; we3 = we; adr3 = adr; dat3 = dat; sel3 = sel; end
    else      begin cyc0 = 1; we0 = we; adr0 = adr; dat0 = dat; sel0 = sel; end
    lat = 0;
    rdt = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (slow && i == 1) begin
        we3 = ~we3; adr3 = ~adr3; dat3 = ~dat3; sel3 = ~sel3;
      end
      if (slow ? ack3 : ack0) begin
        lat = i;
        rdt = slow ? rdt3 : rdt0;
        break;
      end
    end
    if (slow) cyc3 = 0; else cyc0 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    cyc0 = 0; we0 = 0; adr0 = 0; dat0 = 0; sel0 = 0;
    cyc3 = 0; we3 = 0; adr3 = 0; dat3 = 0; sel3 = 0;
    repeat (3) @(negedge clk);
    checks++; if (ack0 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ack0: got %b expected 0", ack0); end
    checks++; if (rdt0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdt0: got %h expected 0", rdt0); end
    checks++; if (oor0 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_oor0: got %b expected 0", oor0); end
    checks++; if (ack3 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ack3: got %b expected 0", ack3); end
    checks++; if (rdt3 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdt3: got %h expected 0", rdt3); end
    checks++; if (oor3 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_oor3: got %b expected 0", oor3); end
    rst_n = 1;
  endtask

  task automatic test_wait0_basic();
    logic [31:0] r;
    int lat;
    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, r, lat);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL w0_write_lat: got %0d expected 1", lat); end
    txn(0, 0, 32'h10, 32'h0, 4'hF, r, lat);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL w0_read_lat: got %0d expected 1", lat); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL w0_read_data: got %h expected deadbeef", r); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b0)  begin errors++; $display("[TB] FAIL w0_ack_drop: got %b expected 0", ack0); end
    checks++; if (rdt0 !== 32'h0) begin errors++; $display("[TB] FAIL w0_rdt_idle: got %h expected 0", rdt0); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    int lat;
    txn(0, 1, 32'h20, 32'h11223344, 4'hF, r, lat);
    txn(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, r, lat);
    txn(0, 0, 32'h20, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL lanes_merge: got %h expected 11bb33dd", r); end
    txn(0, 1, 32'h20, 32'h99999999, 4'b0000, r, lat);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL lanes_sel0_ack: got %0d expected 1", lat); end
    txn(0, 0, 32'h23, 32'h0, 4'b0001, r, lat);
    checks++; if (r !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL lanes_sel0_noop: got %h expected 11bb33dd", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    @(negedge clk);
    cyc0 = 1; we0 = 1; adr0 = 32'h40; dat0 = 32'hA0A0A0A0; sel0 = 4'hF;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack1: got %b expected 1", ack0); end
    adr0 = 32'h44; dat0 = 32'hB1B1B1B1;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got %b expected 0", ack0); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack2: got %b expected 1", ack0); end
    cyc0 = 0;
    txn(0, 0, 32'h40, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'hA0A0A0A0) begin errors++; $display("[TB] FAIL b2b_data1: got %h expected a0a0a0a0", r); end
    txn(0, 0, 32'h44, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'hB1B1B1B1) begin errors++; $display("[TB] FAIL b2b_data2: got %h expected b1b1b1b1", r); end
  endtask

  task automatic test_wait3_latency();
    logic [31:0] r;
    int lat;
    txn(1, 1, 32'h30, 32'h12345678, 4'hF, r, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL w3_write_lat: got %0d expected 4", lat); end
    @(negedge clk);
    cyc3 = 1; we3 = 0; adr3 = 32'h30; sel3 = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (ack3 !== (i == 4)) begin errors++; $display("[TB] FAIL w3_ack_cycle%0d: got %b expected %b", i, ack3, (i == 4)); end
      checks++;
      if (rdt3 !== ((i == 4) ? 32'h12345678 : 32'h0)) begin
        errors++; $display("[TB] FAIL w3_rdt_cycle%0d: got %h expected %h", i, rdt3, ((i == 4) ? 32'h12345678 : 32'h0));
      end
      if (i == 4) cyc3 = 0;
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int lat;
    int acks = 0;
    @(negedge clk);
    cyc3 = 1; we3 = 1; adr3 = 32'h30; dat3 = 32'hCAFEF00D; sel3 = 4'hF;
    @(negedge clk);
    @(negedge clk);
    cyc3 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack3) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL abort_no_ack: got %0d acks expected 0", acks); end
    txn(1, 0, 32'h30, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'h12345678) begin errors++; $display("[TB] FAIL abort_no_write: got %h expected 12345678", r); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] r;
    int lat;
    txn(0, 1, 32'h0, 32'h55AA55AA, 4'hF, r, lat);
    checks++; if (oor0 !== 1'b0) begin errors++; $display("[TB] FAIL oor_clear: got %b expected 0", oor0); end
    txn(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, r, lat);
    checks++; if (lat !== 1)     begin errors++; $display("[TB] FAIL oor_write_ack: got %0d expected 1", lat); end
    checks++; if (oor0 !== 1'b1) begin errors++; $display("[TB] FAIL oor_set: got %b expected 1", oor0); end
    txn(0, 0, 32'h400, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL oor_read_zero: got %h expected 0", r); end
    txn(0, 0, 32'h0, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'h55AA55AA) begin errors++; $display("[TB] FAIL oor_no_alias: got %h expected 55aa55aa", r); end
    checks++; if (oor0 !== 1'b1)      begin errors++; $display("[TB] FAIL oor_sticky: got %b expected 1", oor0); end
    txn(1, 0, 32'h400, 32'h0, 4'hF, r, lat);
    checks++; if (lat !== 4 || r !== 32'h0) begin errors++; $display("[TB] FAIL oor_w3_read: got lat %0d data %h expected 4 0", lat, r); end
    checks++; if (oor3 !== 1'b1) begin errors++; $display("[TB] FAIL oor_w3_set: got %b expected 1", oor3); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int lat;
    @(negedge clk);
    cyc0 = 1; we0 = 0; adr0 = 32'h20; sel0 = 4'hF;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1 || rdt0 !== 32'h11BB33DD) begin
      errors++; $display("[TB] FAIL arst_pre_ack: got ack %b data %h expected 1 11bb33dd", ack0, rdt0);
    end
    #2 rst_n = 0;
    #1;
    checks++; if (ack0 !== 1'b0)  begin errors++; $display("[TB] FAIL arst_ack0: got %b expected 0", ack0); end
    checks++; if (rdt0 !== 32'h0) begin errors++; $display("[TB] FAIL arst_rdt0: got %h expected 0", rdt0); end
    checks++; if (oor0 !== 1'b0)  begin errors++; $display("[TB] FAIL arst_oor0: got %b expected 0", oor0); end
    checks++; if (oor3 !== 1'b0)  begin errors++; $display("[TB] FAIL arst_oor3: got %b expected 0", oor3); end
    cyc0 = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cyc3 = 1; we3 = 1; adr3 = 32'h30; dat3 = 32'hBAD0BAD0; sel3 = 4'hF;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (ack3 !== 1'b0 || rdt3 !== 32'h0) begin
      errors++; $display("[TB] FAIL arst_busy: got ack %b data %h expected 0 0", ack3, rdt3);
    end
    cyc3 = 0;
    @(negedge clk);
    rst_n = 1;
    txn(1, 1, 32'h34, 32'h0F0F0F0F, 4'hF, r, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL arst_next_lat: got %0d expected 4", lat); end
    txn(1, 0, 32'h34, 32'h0, 4'hF, r, lat);
    checks++; if (r !== 32'h0F0F0F0F) begin errors++; $display("[TB] FAIL arst_next_data: got %h expected 0f0f0f0f", r); end
  endtask

  initial begin
    test_reset();
    test_wait0_basic();
    test_byte_lanes();
    test_back_to_back();
    test_wait3_latency();
    test_abort();
    test_out_of_range();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
